// File: rtl/switch_pkg.sv
// Shared switch definitions: port address type, port count, default packet layout.
package switch_pkg;

    localparam int NUM_PORTS  = 4;
    localparam int PKT_DATA_W = 8;

    typedef logic [1:0] port_addr_t;

    typedef struct packed {
        port_addr_t            target;
        logic [PKT_DATA_W-1:0] data;
    } packet_t;

endpackage

// File: rtl/ingress_fifo_mem.sv
// Ingress FIFO storage: DEPTH packed packet entries, one write port, one
// asynchronous read port. Contents are not reset.
module ingress_fifo_mem
    import switch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(packet_t)
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_pkt,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_pkt
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the incoming packet at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_pkt;
        end
    end

    // Head entry read straight out of the registered array.
    always_comb begin
        rd_pkt = mem[rd_addr];
    end

endmodule

// File: rtl/port_ingress_buffer.sv
// Per-port ingress buffer: accepts upstream packets into a FIFO, drops
// self-addressed ones, and presents the head entry to the switch.
// Optional statistics counters are built when INGRESS_STATS_EN is defined.
module port_ingress_buffer
    import switch_pkg::*;
#(
    parameter int PORT_ID = 0,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up_valid,
    output logic                     up_ready,
    input  logic [1:0]               up_target,
    input  logic [DATA_W-1:0]        up_data,
    output logic                     sw_valid,
    input  logic                     sw_ready,
    output logic [1:0]               sw_source,
    output logic [1:0]               sw_target,
    output logic [DATA_W-1:0]        sw_data,
    output logic [$clog2(DEPTH):0]   level
`ifdef INGRESS_STATS_EN
    ,
    output logic [15:0]              drop_cnt,
    output logic [15:0]              fwd_cnt
`endif
);

    localparam int         AW  = $clog2(DEPTH);
    localparam int         LW  = AW + 1;
    localparam port_addr_t SRC = port_addr_t'(PORT_ID % NUM_PORTS);

    typedef struct packed {
        port_addr_t        target;
        logic [DATA_W-1:0] data;
    } pkt_t;

    localparam int PW = $bits(pkt_t);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_acc;
    logic          self_addr;
    logic          store;
    logic          pop;
    pkt_t          wr_pkt;
    pkt_t          head;
    logic [PW-1:0] head_bits;

    // Handshake decode; up_ready depends only on the registered level.
    always_comb begin
        up_ready  = (level != LW'(DEPTH));
        sw_valid  = (level != '0);
        push_acc  = up_valid && up_ready;
        self_addr = (up_target == SRC);
        store     = push_acc && !self_addr;
        pop       = sw_valid && sw_ready;
        wr_pkt    = '{target: up_target, data: up_data};
        head      = pkt_t'(head_bits);
        sw_source = SRC;
        sw_target = head.target;
        sw_data   = head.data;
    end

    // Pointer and occupancy tracking; pointers wrap through the power-of-two width.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({store, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    ingress_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (PW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (store),
        .wr_addr (wr_ptr),
        .wr_pkt  (wr_pkt),
        .rd_addr (rd_ptr),
        .rd_pkt  (head_bits)
    );

`ifdef INGRESS_STATS_EN
    // Saturating drop and forward statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            fwd_cnt  <= '0;
        end else begin
            if (push_acc && self_addr && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (pop && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/port_ingress_buffer.md
PORT_INGRESS_BUFFER -- requirements
Module: port_ingress_buffer

Interface
REQ-001 Parameter PORT_ID, default 0: this port's 2-bit switch address, driven on every sw_source.
REQ-002 Parameter DATA_W, default 8: payload width in bits.
REQ-003 Parameter DEPTH, default 4: FIFO entries; power of two, at least 2.
REQ-004 The block SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 up_valid  in  1  upstream packet offered.
REQ-008 up_ready  out  1  buffer can accept.
REQ-009 up_target  in  2  destination port of the offered packet.
REQ-010 up_data  in  DATA_W  offered payload.
REQ-011 sw_valid  out  1  packet presented to the switch port input.
REQ-012 sw_ready  in  1  switch port accepts.
REQ-013 sw_source  out  2  equals PORT_ID.
REQ-014 sw_target  out  2  head-entry target.
REQ-015 sw_data  out  DATA_W  head-entry payload.
REQ-016 level  out  $clog2(DEPTH)+1  current occupancy.
REQ-017 drop_cnt / fwd_cnt  out  16 each  statistics; present only with INGRESS_STATS_EN.

Function
REQ-018 The block SHALL transfer upstream on up_valid && up_ready and downstream on sw_valid && sw_ready.
REQ-019 up_ready SHALL equal (level != DEPTH), with no combinational path from sw_ready; a full buffer never accepts, even when popping in the same cycle.
REQ-020 An accepted packet with up_target == PORT_ID is self-addressed and SHALL be consumed but not stored.
REQ-021 sw_valid SHALL equal (level != 0); sw_target and sw_data SHALL come from the head entry in registered storage.
REQ-022 A packet written into an empty buffer SHALL appear on sw_valid the next cycle; latency is 1 cycle, with no bypass.
REQ-023 When a packet is presented, sw_target, sw_data and sw_valid SHALL hold stable until the switch accepts it.
REQ-024 When one packet is stored and one is popped in the same cycle, level SHALL be unchanged and the pointers SHALL both advance.
REQ-025 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-026 Packets SHALL leave in acceptance order; none are lost except by REQ-020.

Reset
REQ-027 While rst is high at a clock edge, the block SHALL zero level, the pointers and the counters, and SHALL drive up_ready=1 and sw_valid=0 from the next cycle.
REQ-028 Reset mid-operation SHALL discard all stored packets; a handshake in the reset cycle SHALL have no effect.
REQ-029 Storage contents need no reset; sw_data and sw_target are don't-care while sw_valid=0.

Configuration
REQ-030 With INGRESS_STATS_EN defined, the block SHALL provide the counters:
- drop_cnt +1 per self-addressed packet.
- fwd_cnt +1 per downstream transfer.
- Both saturate at 16'hFFFF.
REQ-031 Without INGRESS_STATS_EN, the counter ports and logic SHALL be absent, and all other behaviour is identical.

Structure
REQ-032 A shared package switch_pkg SHALL hold:
- the port-address typedef (2 bits);
- the NUM_PORTS=4 constant;
- a packet struct of {target, data}.
REQ-033 Storage SHALL be a sub-module, ingress_fifo_mem (DEPTH x packet struct, 1 write/1 read port); control and counters stay in port_ingress_buffer.

Verification
REQ-034 The bench SHALL cover these scenarios:
- PORT_ID=1; push target=2, data=8'hA5 with sw_ready=1 -> next cycle sw_valid=1, sw_source=1, sw_target=2, sw_data=A5; level back to 0 after the pop.
- sw_ready=0; push 4 packets -> level=4, up_ready=0; a 5th up_valid is not accepted; sw_ready=1 then drains in order.
- Push target=1 at PORT_ID=1 -> up_ready=1, level stays 0, sw_valid stays 0; drop_cnt=1 when stats are enabled.
- Keep level=2 with a concurrent push and pop every cycle for 10 cycles -> level constant at 2, order preserved, pointers wrap.
- Assert rst with level=3 -> next cycle level=0, sw_valid=0, up_ready=1; the next pushed packet is the first one out.
- Stats enabled: 70000 forwarded packets -> fwd_cnt=16'hFFFF, no wrap.
